output_accum_unit: RTL and testbench
====================================

# output_accum_unit

Read-modify-write accumulator between the output memory and the PE array. It takes partial-sum packets read from the output memory (data, address, valid; two lanes) and adds the matching PE partial results. The sums are returned as write-back packets to the output memory's CIM write port. A one-deep forwarding path keeps back-to-back updates to the same address from reading stale memory data.

## Interface
Parameters:
- DATA_W, 512, packet width (whole bus).
- ELEM_W, 32, element width; DATA_W/ELEM_W = 16 signed elements per packet.
- ADDR_W, 8, packet address width.
- CNT_W, 16, write-back packet counter width.

Ports:
- clk  in  1  clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- first_pass_in  in  1  level; when 1, memory data is ignored and the base is 0.
- mem_valid_1_in, mem_valid_2_in  in  1  read-packet valid from output memory.
- mem_addr_1_in, mem_addr_2_in  in  ADDR_W  read-packet address.
- mem_data_1_in, mem_data_2_in  in  DATA_W  stored partial sums.
- pe_data_1_in, pe_data_2_in  in  DATA_W  PE partial sums, aligned with the mem packet of the same lane.
- wb_valid_1_out, wb_valid_2_out  out  1  write-back valid (drives memory CIM write valid).
- wb_addr_1_out, wb_addr_2_out  out  ADDR_W  write-back address.
- wb_data_1_out, wb_data_2_out  out  DATA_W  accumulated result.
- pkt_count_out  out  CNT_W  count of write-back packets issued.
- sat_flag_out  out  1  sticky; at least one element overflowed.

## Operation
- Two-stage pipeline: S1 input register, S2 output register (the wb_* outputs are S2).
- S1 captures per lane: valid, address, mem data, PE data, and first_pass_in.
  - Data and address are captured only when valid=1.
  - Valid is captured every cycle.
- Base selection per lane, S1→S2, in priority order:
  1. first_pass captured 1 → base 0.
  2. Any S2 lane valid with address equal to the S1 lane address → that S2 lane's wb_data. If both S2 lanes match, lane 2 wins.
  3. Otherwise → the captured mem data.
- Intra-packet merge: when both S1 lanes are valid with equal addresses:
  - lane 2 result = lane 1 result + pe_data_2;
  - wb_valid_1 for that packet is 0 and wb_valid_2 is 1;
  - lane 1's base-selection rules still apply to the lane 1 term.
- Arithmetic: 16 independent signed ELEM_W adds per lane with no carry between elements. Overflow handling is set by the configuration macro.
- Lanes whose S1 valid is 0 produce wb_valid 0. Their wb_addr/wb_data hold their previous values.
- pkt_count_out increments by (wb_valid_1 + wb_valid_2) on each clk edge where the S2 outputs are valid. It wraps modulo 2^CNT_W.
- sat_flag_out sets on any overflow and clears only on reset. Without the macro it sets on wrap.

## Timing
- Latency: a packet sampled at edge N appears on wb_* after edge N+1, i.e. 2 cycles. Throughput is one packet per lane per cycle with no stalls; the block has no backpressure.
- Forwarding covers the one-cycle gap between wb_* presentation and the memory actually committing the write. Packets spaced 2 or more cycles apart read correct data from memory.
- Reset (rst_n=0 at an edge): all S1/S2 valids, wb_valid_*, wb_addr_*, wb_data_*, pkt_count_out and sat_flag_out go to 0.
  - In-flight packets are dropped.
  - Outputs stay 0 until 2 cycles after rst_n returns to 1 with valid input.
- Reset during a merge or forward case drops both lanes; no partial write-back occurs.
- Simultaneous first_pass and forward match: first_pass wins and the base is 0.

## Configuration
- ACCUM_SAT_EN defined:
  - each element add saturates to +2^(ELEM_W-1)-1 / -2^(ELEM_W-1);
  - sat_flag_out sets when any element clamps.
- ACCUM_SAT_EN undefined:
  - two's-complement wrap;
  - sat_flag_out sets when any element's signed add overflows (the flag still reports the overflow).

## Test plan
- Reset, then lane 1: addr 0x05, mem elements all 10, pe all 3 → 2 cycles later wb_valid_1=1, addr 0x05, all elements 13; pkt_count_out=1.
- first_pass_in=1, mem all 0x7F, pe all 4 → wb elements all 4.
- Back-to-back lane 1 addr 0x20, pe=1 each cycle for 3 cycles, mem stale all 0 → wb elements 1, 2, 3 (forwarding).
- Same cycle, both lanes addr 0x11, mem 5, pe1 2, pe2 7 → wb_valid_1=0, wb_valid_2=1, elements 14; pkt_count_out +1.
- Element 0 at 0x7FFFFFFF + 1: with ACCUM_SAT_EN → 0x7FFFFFFF; without → 0x80000000. sat_flag_out=1 in both builds.
- Assert rst_n=0 while packets are in S1 and S2 → no wb_valid afterwards; counter and flag both 0.

Source files
------------

// File: rtl/output_accum_if.sv
// Bundle between the output memory / PE array and output_accum_unit: read packets in, write-back packets out.
interface output_accum_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              first_pass_in;
  logic              mem_valid_1_in, mem_valid_2_in;
  logic [ADDR_W-1:0] mem_addr_1_in,  mem_addr_2_in;
  logic [DATA_W-1:0] mem_data_1_in,  mem_data_2_in;
  logic [DATA_W-1:0] pe_data_1_in,   pe_data_2_in;
  logic              wb_valid_1_out, wb_valid_2_out;
  logic [ADDR_W-1:0] wb_addr_1_out,  wb_addr_2_out;
  logic [DATA_W-1:0] wb_data_1_out,  wb_data_2_out;
  logic [CNT_W-1:0]  pkt_count_out;
  logic              sat_flag_out;

  modport master (
    output first_pass_in, mem_valid_1_in, mem_valid_2_in, mem_addr_1_in, mem_addr_2_in,
           mem_data_1_in, mem_data_2_in, pe_data_1_in, pe_data_2_in,
    input  wb_valid_1_out, wb_valid_2_out, wb_addr_1_out, wb_addr_2_out,
           wb_data_1_out, wb_data_2_out, pkt_count_out, sat_flag_out
  );

  modport slave (
    input  first_pass_in, mem_valid_1_in, mem_valid_2_in, mem_addr_1_in, mem_addr_2_in,
           mem_data_1_in, mem_data_2_in, pe_data_1_in, pe_data_2_in,
    output wb_valid_1_out, wb_valid_2_out, wb_addr_1_out, wb_addr_2_out,
           wb_data_1_out, wb_data_2_out, pkt_count_out, sat_flag_out
  );
endinterface

// File: rtl/output_accum_unit.sv
// Two-lane read-modify-write accumulator with one-deep write-back forwarding; ACCUM_SAT_EN selects saturating adds.
// Latency 2 cycles (S1 input reg, S2 output reg); one packet per lane per cycle, no backpressure.
module output_accum_unit #(
  parameter int DATA_W = 512,
  parameter int ELEM_W = 32,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst_n,
  output_accum_if.slave io
);
  localparam int NELEM = DATA_W / ELEM_W;

  logic              s1_v1_q, s1_v1_d, s1_v2_q, s1_v2_d, s1_fp_q, s1_fp_d;
  logic [ADDR_W-1:0] s1_a1_q, s1_a1_d, s1_a2_q, s1_a2_d;
  logic [DATA_W-1:0] s1_m1_q, s1_m1_d, s1_m2_q, s1_m2_d;
  logic [DATA_W-1:0] s1_p1_q, s1_p1_d, s1_p2_q, s1_p2_d;
  logic              wb_v1_q, wb_v1_d, wb_v2_q, wb_v2_d;
  logic [ADDR_W-1:0] wb_a1_q, wb_a1_d, wb_a2_q, wb_a2_d;
  logic [DATA_W-1:0] wb_d1_q, wb_d1_d, wb_d2_q, wb_d2_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;

  logic              merge, ovf1, ovf2;
  logic [DATA_W-1:0] base1, base2, sum1, sum2;

  // Element-wise signed add; MSB of the result flags overflow in any element.
  function automatic logic [DATA_W:0] vec_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    logic              ovf;
    logic [ELEM_W-1:0] ea, eb, es;
    s   = '0;
    ovf = 1'b0;
    for (int i = 0; i < NELEM; i++) begin
      ea = a[i*ELEM_W +: ELEM_W];
      eb = b[i*ELEM_W +: ELEM_W];
      es = ea + eb;
      if ((ea[ELEM_W-1] == eb[ELEM_W-1]) && (es[ELEM_W-1] != ea[ELEM_W-1])) begin
        ovf = 1'b1;
`ifdef ACCUM_SAT_EN
        es = ea[ELEM_W-1] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
`else
        es = ea + eb;
`endif
      end
      s[i*ELEM_W +: ELEM_W] = es;
    end
    return {ovf, s};
  endfunction

  always_comb begin
    s1_v1_d = io.mem_valid_1_in;
    s1_v2_d = io.mem_valid_2_in;
    s1_fp_d = io.first_pass_in;
    s1_a1_d = io.mem_valid_1_in ? io.mem_addr_1_in : s1_a1_q;
    s1_m1_d = io.mem_valid_1_in ? io.mem_data_1_in : s1_m1_q;
    s1_p1_d = io.mem_valid_1_in ? io.pe_data_1_in  : s1_p1_q;
    s1_a2_d = io.mem_valid_2_in ? io.mem_addr_2_in : s1_a2_q;
    s1_m2_d = io.mem_valid_2_in ? io.mem_data_2_in : s1_m2_q;
    s1_p2_d = io.mem_valid_2_in ? io.pe_data_2_in  : s1_p2_q;

    merge = s1_v1_q && s1_v2_q && (s1_a1_q == s1_a2_q);

    // S2 still holds the result memory has not committed yet; lane 2 is the newer write.
    if (s1_fp_q)                             base1 = '0;
    else if (wb_v2_q && wb_a2_q == s1_a1_q)  base1 = wb_d2_q;
    else if (wb_v1_q && wb_a1_q == s1_a1_q)  base1 = wb_d1_q;
    else                                     base1 = s1_m1_q;
    {ovf1, sum1} = vec_add(base1, s1_p1_q);

    if (merge)                               base2 = sum1;
    else if (s1_fp_q)                        base2 = '0;
    else if (wb_v2_q && wb_a2_q == s1_a2_q)  base2 = wb_d2_q;
    else if (wb_v1_q && wb_a1_q == s1_a2_q)  base2 = wb_d1_q;
    else                                     base2 = s1_m2_q;
    {ovf2, sum2} = vec_add(base2, s1_p2_q);

    wb_v1_d = s1_v1_q && !merge;
    wb_v2_d = s1_v2_q;
    wb_a1_d = wb_v1_d ? s1_a1_q : wb_a1_q;
    wb_d1_d = wb_v1_d ? sum1    : wb_d1_q;
    wb_a2_d = wb_v2_d ? s1_a2_q : wb_a2_q;
    wb_d2_d = wb_v2_d ? sum2    : wb_d2_q;

    cnt_d = cnt_q + CNT_W'(wb_v1_d) + CNT_W'(wb_v2_d);
    sat_d = sat_q | (s1_v1_q & ovf1) | (s1_v2_q & ovf2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v1_q <= 1'b0;  s1_v2_q <= 1'b0;  s1_fp_q <= 1'b0;
      s1_a1_q <= '0;    s1_a2_q <= '0;
      s1_m1_q <= '0;    s1_m2_q <= '0;
      s1_p1_q <= '0;    s1_p2_q <= '0;
      wb_v1_q <= 1'b0;  wb_v2_q <= 1'b0;
      wb_a1_q <= '0;    wb_a2_q <= '0;
      wb_d1_q <= '0;    wb_d2_q <= '0;
      cnt_q   <= '0;    sat_q   <= 1'b0;
    end else begin
      s1_v1_q <= s1_v1_d;  s1_v2_q <= s1_v2_d;  s1_fp_q <= s1_fp_d;
      s1_a1_q <= s1_a1_d;  s1_a2_q <= s1_a2_d;
      s1_m1_q <= s1_m1_d;  s1_m2_q <= s1_m2_d;
      s1_p1_q <= s1_p1_d;  s1_p2_q <= s1_p2_d;
      wb_v1_q <= wb_v1_d;  wb_v2_q <= wb_v2_d;
      wb_a1_q <= wb_a1_d;  wb_a2_q <= wb_a2_d;
      wb_d1_q <= wb_d1_d;  wb_d2_q <= wb_d2_d;
      cnt_q   <= cnt_d;    sat_q   <= sat_d;
    end
  end

  assign io.wb_valid_1_out = wb_v1_q;
  assign io.wb_valid_2_out = wb_v2_q;
  assign io.wb_addr_1_out  = wb_a1_q;
  assign io.wb_addr_2_out  = wb_a2_q;
  assign io.wb_data_1_out  = wb_d1_q;
  assign io.wb_data_2_out  = wb_d2_q;
  assign io.pkt_count_out  = cnt_q;
  assign io.sat_flag_out   = sat_q;
endmodule

// File: tb/tb_output_accum_unit.sv
// Scoreboard bench for output_accum_unit: directed test-plan cases, random traffic, reset mid-flight.
module tb_output_accum_unit;
  localparam longint EMAX = 64'sd2147483647;
  localparam longint EMIN = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  output_accum_if #(.DATA_W(512), .ADDR_W(8), .CNT_W(16)) io();
  output_accum_unit dut (.clk(clk), .rst_n(rst_n), .io(io));

  int checks = 0;
  int errors = 0;

  logic [511:0] mem_arr [256];   // output memory as seen by the unit
  logic [511:0] truth   [256];   // architecturally correct accumulated value per address
  logic [519:0] q1 [$];
  logic [519:0] q2 [$];
  logic [15:0]  exp_cnt = '0;
  logic         exp_sat = 1'b0;

  function automatic logic [512:0] ref_add(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] s;
    logic         ov;
    longint       x;
    ov = 1'b0;
    s  = '0;
    for (int i = 0; i < 16; i++) begin
      x = longint'($signed(a[i*32 +: 32])) + longint'($signed(b[i*32 +: 32]));
      if (x > EMAX || x < EMIN) begin
        ov = 1'b1;
`ifdef ACCUM_SAT_EN
        x = (x > 0) ? EMAX : EMIN;
`endif
      end
      s[i*32 +: 32] = x[31:0];
    end
    return {ov, s};
  endfunction

  function automatic logic [511:0] fill(input int v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [511:0] rand_vec();
    logic [511:0] r;
    int e;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 15) == 0) e = int'($urandom);
      else e = int'($urandom_range(0, 200)) - 100;
      r[i*32 +: 32] = e;
    end
    return r;
  endfunction

  // Memory commits whatever write-back is currently presented before serving the next read.
  task automatic commit();
    if (io.wb_valid_1_out) mem_arr[io.wb_addr_1_out] = io.wb_data_1_out;
    if (io.wb_valid_2_out) mem_arr[io.wb_addr_2_out] = io.wb_data_2_out;
  endtask

  task automatic issue(input bit v1, input logic [7:0] a1, input logic [511:0] p1,
                       input bit v2, input logic [7:0] a2, input logic [511:0] p2, input bit fp);
    logic [512:0] r;
    logic [511:0] base;
    bit same;
    @(negedge clk); #1;
    commit();
    io.first_pass_in  = fp;
    io.mem_valid_1_in = v1;  io.mem_addr_1_in = a1;  io.mem_data_1_in = mem_arr[a1];  io.pe_data_1_in = p1;
    io.mem_valid_2_in = v2;  io.mem_addr_2_in = a2;  io.mem_data_2_in = mem_arr[a2];  io.pe_data_2_in = p2;
    same = v1 && v2 && (a1 == a2);
    if (v1) begin
      r = ref_add(fp ? 512'd0 : truth[a1], p1);
      truth[a1] = r[511:0];
      exp_sat |= r[512];
      if (!same) begin
        q1.push_back({a1, r[511:0]});
        exp_cnt = exp_cnt + 16'd1;
      end
    end
    if (v2) begin
      base = same ? truth[a2] : (fp ? 512'd0 : truth[a2]);
      r = ref_add(base, p2);
      truth[a2] = r[511:0];
      exp_sat |= r[512];
      q2.push_back({a2, r[511:0]});
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 8'd0, 512'd0, 1'b0, 8'd0, 512'd0, 1'b0);
  endtask

  task automatic preload(input logic [7:0] a, input logic [511:0] v);
    mem_arr[a] = v;
    truth[a]   = v;
  endtask

  task automatic check_status(input string name);
    checks++;
    if (io.pkt_count_out !== exp_cnt) begin
      errors++;
      $display("FAIL %s_count: got %0d expected %0d", name, io.pkt_count_out, exp_cnt);
    end
    checks++;
    if (io.sat_flag_out !== exp_sat) begin
      errors++;
      $display("FAIL %s_sat: got %0b expected %0b", name, io.sat_flag_out, exp_sat);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) idle(1);
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d/%0d packets outstanding, required 0", name, q1.size(), q2.size());
    end
    idle(1);
    check_status(name);
  endtask

  always @(negedge clk) begin
    logic [519:0] e;
    if (io.wb_valid_1_out) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL wb1_spurious: addr %0h with nothing expected", io.wb_addr_1_out);
      end else begin
        e = q1.pop_front();
        if (io.wb_addr_1_out !== e[519:512] || io.wb_data_1_out !== e[511:0]) begin
          errors++;
          $display("FAIL wb1: addr %0h el0 %0h, required addr %0h el0 %0h",
                   io.wb_addr_1_out, io.wb_data_1_out[31:0], e[519:512], e[31:0]);
        end
      end
    end
    if (io.wb_valid_2_out) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL wb2_spurious: addr %0h with nothing expected", io.wb_addr_2_out);
      end else begin
        e = q2.pop_front();
        if (io.wb_addr_2_out !== e[519:512] || io.wb_data_2_out !== e[511:0]) begin
          errors++;
          $display("FAIL wb2: addr %0h el0 %0h, required addr %0h el0 %0h",
                   io.wb_addr_2_out, io.wb_data_2_out[31:0], e[519:512], e[31:0]);
        end
      end
    end
  end

  initial begin
    logic [511:0] v;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = '0;
      truth[i]   = '0;
    end
    io.first_pass_in = 1'b0;
    io.mem_valid_1_in = 1'b0; io.mem_addr_1_in = '0; io.mem_data_1_in = '0; io.pe_data_1_in = '0;
    io.mem_valid_2_in = 1'b0; io.mem_addr_2_in = '0; io.mem_data_2_in = '0; io.pe_data_2_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    check_status("reset");

    preload(8'h05, fill(10));
    issue(1'b1, 8'h05, fill(3), 1'b0, 8'h00, 512'd0, 1'b0);
    drain("lane1_basic");

    preload(8'h06, fill(32'h7F));
    issue(1'b1, 8'h06, fill(4), 1'b0, 8'h00, 512'd0, 1'b1);
    drain("first_pass");

    preload(8'h20, 512'd0);
    repeat (3) issue(1'b1, 8'h20, fill(1), 1'b0, 8'h00, 512'd0, 1'b0);
    drain("forward");

    preload(8'h11, fill(5));
    issue(1'b1, 8'h11, fill(2), 1'b1, 8'h11, fill(7), 1'b0);
    drain("merge");

    v = '0;
    v[31:0] = 32'h7FFF_FFFF;
    preload(8'h40, v);
    v[31:0] = 32'h1;
    issue(1'b1, 8'h40, v, 1'b0, 8'h00, 512'd0, 1'b0);
    drain("overflow");

    // first_pass together with a pending forward on the same address
    issue(1'b1, 8'h50, fill(9), 1'b0, 8'h00, 512'd0, 1'b0);
    issue(1'b0, 8'h00, 512'd0, 1'b1, 8'h50, fill(6), 1'b1);
    drain("fp_vs_forward");

    for (int i = 0; i < 400; i++)
      issue($urandom_range(0, 3) != 0, 8'h80 + 8'($urandom_range(0, 3)), rand_vec(),
            $urandom_range(0, 3) != 0, 8'h80 + 8'($urandom_range(0, 3)), rand_vec(),
            $urandom_range(0, 7) == 0);
    drain("random");

    issue(1'b1, 8'h30, fill(1), 1'b1, 8'h31, fill(2), 1'b0);
    issue(1'b1, 8'h32, fill(3), 1'b1, 8'h32, fill(4), 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    io.mem_valid_1_in = 1'b0;
    io.mem_valid_2_in = 1'b0;
    q1.delete();
    q2.delete();
    exp_cnt = '0;
    exp_sat = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    check_status("reset_midflight");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
